// File: rtl/led_pkg.sv
// Shared mode encodings and width helper for the LED pattern controller.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler dividing the system clock down to a one-cycle base tick strobe.
module tick_gen #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with a one-cycle
// configuration handshake and registered, polarity-adjusted LED outputs.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          CLK_HZ      = 25_000_000,
  parameter int          TICK_HZ     = 1000,
  parameter int          PWM_BITS    = 8,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter logic [1:0]  INIT_MODE   = 2'd0,
  parameter logic [15:0] INIT_PERIOD = 16'd500,
  localparam int         CW          = cw(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  logic                ready_q;
  logic                accept;
  logic                bad_ch;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CHANNELS-1:0] on;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign cfg_ready = ready_q;
  assign accept    = cfg_valid && ready_q;
  assign bad_ch    = (32'(cfg_ch) >= CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      cfg_err <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      ready_q <= 1'b1;
      cfg_err <= accept && bad_ch;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mode_t               mode;
    logic [15:0]         period;
    logic [15:0]         bcnt;
    logic [15:0]         limit;
    logic [PWM_BITS-1:0] duty;
    logic                ph;
    logic                wr;
    logic                lit;

    assign wr    = accept && !bad_ch && (cfg_ch == CW'(i));
    // A zero period blinks like a period of one tick.
    assign limit = (period == 16'd0) ? 16'd0 : period - 16'd1;

    // A config write takes priority over a blink step in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode   <= mode_t'(INIT_MODE);
        period <= INIT_PERIOD;
        duty   <= '0;
        bcnt   <= '0;
        ph     <= 1'b0;
      end else if (wr) begin
        mode   <= mode_t'(cfg_mode);
        period <= cfg_period;
        duty   <= cfg_duty;
        bcnt   <= '0;
        ph     <= 1'b1;
      end else if (tick && (mode == MODE_BLINK)) begin
        if (bcnt >= limit) begin
          ph   <= ~ph;
          bcnt <= '0;
        end else begin
          bcnt <= bcnt + 16'd1;
        end
      end
    end

    always_comb begin
      lit = 1'b0;
      unique case (mode)
        MODE_OFF:   lit = 1'b0;
        MODE_ON:    lit = 1'b1;
        MODE_BLINK: lit = ph;
        MODE_PWM:   lit = (pwm_cnt < duty);
      endcase
    end

    assign on[i] = lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      led <= on ^ {CHANNELS{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a 4-channel and a 3-channel instance
// checked every cycle against a closed-form model of the expected LED levels.
module tb_led_pattern_ctrl;
  import led_pkg::*;

  typedef struct {
    logic [3:0] led;
    logic       tick;
    logic       ready;
    logic       err;
    logic [2:0] led3;
    logic       err3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [3:0]  cfg_duty = '0;
  logic        cfg_err;
  logic        tick;
  logic [3:0]  led;

  logic        cfg3_valid = 1'b0;
  logic        cfg3_ready;
  logic [1:0]  cfg3_ch = '0;
  logic [1:0]  cfg3_mode = '0;
  logic [15:0] cfg3_period = '0;
  logic [3:0]  cfg3_duty = '0;
  logic        cfg3_err;
  logic        tick3;
  logic [2:0]  led3;

  int assert_count = 0;
  int fail_count = 0;
  int edge_n = 0;

  exp_t        sb[$];
  logic [1:0]  m_mode  [2][4];
  logic [15:0] m_per   [2][4];
  logic [3:0]  m_duty  [2][4];
  int          m_cedge [2][4];

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CHANNELS(4), .CLK_HZ(100), .TICK_HZ(10), .PWM_BITS(4),
    .ACTIVE_LOW(1'b1), .INIT_MODE(2'd0), .INIT_PERIOD(16'd500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_err(cfg_err), .tick(tick), .led(led)
  );

  led_pattern_ctrl #(
    .CHANNELS(3), .CLK_HZ(100), .TICK_HZ(10), .PWM_BITS(4),
    .ACTIVE_LOW(1'b1), .INIT_MODE(2'd0), .INIT_PERIOD(16'd500)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_ch(cfg3_ch), .cfg_mode(cfg3_mode), .cfg_period(cfg3_period),
    .cfg_duty(cfg3_duty), .cfg_err(cfg3_err), .tick(tick3), .led(led3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit to3, input logic [1:0] ch, input mode_t md,
                               input logic [15:0] per, input logic [3:0] dty);
    if (!to3) begin
      cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = md; cfg_period = per; cfg_duty = dty;
    end else begin
      cfg3_valid = 1'b1; cfg3_ch = ch; cfg3_mode = md; cfg3_period = per; cfg3_duty = dty;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg3_valid = 1'b0;
  endtask

  // On-level of a channel in the state left by edge e. Blink phase is derived
  // from the number of ticks consumed since the last write (ticks land on
  // edges that are multiples of 10); PWM from the free-running edge count.
  function automatic bit onLevel(input logic [1:0] md, input logic [15:0] per,
                                 input logic [3:0] dty, input int cedge, input int e);
    int p;
    int t;
    case (md)
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: begin
        p = (per == 16'd0) ? 1 : int'(per);
        t = e / 10 - cedge / 10;
        return ((t / p) % 2) == 0;
      end
      default: return (e % 16) < int'(dty);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t ex;
    if (!rst_n) begin
      edge_n = 0;
      sb.delete();
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin
          m_mode[d][c] = 2'd0; m_per[d][c] = 16'd500; m_duty[d][c] = 4'd0; m_cedge[d][c] = 0;
        end
      end
    end else begin
      for (int c = 0; c < 4; c++)
        ex.led[c] = ~onLevel(m_mode[0][c], m_per[0][c], m_duty[0][c], m_cedge[0][c], edge_n);
      for (int c = 0; c < 3; c++)
        ex.led3[c] = ~onLevel(m_mode[1][c], m_per[1][c], m_duty[1][c], m_cedge[1][c], edge_n);
      ex.tick  = ((edge_n + 1) % 10) == 9;
      ex.ready = 1'b1;
      ex.err   = 1'b0;
      ex.err3  = 1'b0;
      if (edge_n >= 1) begin
        if (cfg_valid) begin
          m_mode[0][cfg_ch] = cfg_mode; m_per[0][cfg_ch] = cfg_period;
          m_duty[0][cfg_ch] = cfg_duty; m_cedge[0][cfg_ch] = edge_n + 1;
        end
        if (cfg3_valid) begin
          if (cfg3_ch < 2'd3) begin
            m_mode[1][cfg3_ch] = cfg3_mode; m_per[1][cfg3_ch] = cfg3_period;
            m_duty[1][cfg3_ch] = cfg3_duty; m_cedge[1][cfg3_ch] = edge_n + 1;
          end else begin
            ex.err3 = 1'b1;
          end
        end
      end
      edge_n++;
      sb.push_back(ex);
    end
  end

  always @(negedge clk) begin
    exp_t ex;
    if (sb.size() == 0) begin
      checkOutput("rst_led", led, 4'hF);
      checkOutput("rst_ready", cfg_ready, 1'b0);
      checkOutput("rst_tick", tick, 1'b0);
      checkOutput("rst_err", cfg_err, 1'b0);
      checkOutput("rst_led3", led3, 3'h7);
      checkOutput("rst_ready3", cfg3_ready, 1'b0);
    end else begin
      ex = sb.pop_front();
      checkOutput("led", led, ex.led);
      checkOutput("tick", tick, ex.tick);
      checkOutput("ready", cfg_ready, ex.ready);
      checkOutput("err", cfg_err, ex.err);
      checkOutput("led3", led3, ex.led3);
      checkOutput("err3", cfg3_err, ex.err3);
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (25) @(negedge clk);

    applyStimulus(1'b0, 2'd1, MODE_ON, 16'd0, 4'd0);
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 2'd0, MODE_BLINK, 16'd3, 4'd0);
    repeat (130) @(negedge clk);
    applyStimulus(1'b0, 2'd0, MODE_BLINK, 16'd0, 4'd0);
    repeat (40) @(negedge clk);

    applyStimulus(1'b0, 2'd2, MODE_PWM, 16'd0, 4'd4);
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 2'd2, MODE_PWM, 16'd0, 4'd0);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 2'd2, MODE_PWM, 16'd0, 4'd15);
    repeat (40) @(negedge clk);

    applyStimulus(1'b1, 2'd3, MODE_ON, 16'd0, 4'd0);
    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 2'd0, MODE_BLINK, 16'd1, 4'd0);
    repeat (25) @(negedge clk);
    // Land the rewrite on an edge that also consumes a toggle tick.
    while ((edge_n % 10) != 9) @(negedge clk);
    applyStimulus(1'b1, 2'd0, MODE_BLINK, 16'd1, 4'd0);
    repeat (30) @(negedge clk);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_led", led, 4'hF);
    checkOutput("async_led3", led3, 3'h7);
    checkOutput("async_ready", cfg_ready, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
